// File: rtl/demux_pkg.sv
// Shared constants and state types for the two-channel demux deserializer.
package demux_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {SHIFT, LAST} collect_t;
    typedef enum logic {EMPTY, FULL} out_t;

    // Bit counter width for a given word size (cnt spans 0..WIDTH-1).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/deser_lane.sv
// One deserializer channel: MSB-first collector feeding a valid/ack holding stage
// with a sticky overflow flag.
module deser_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample,
    input  logic             bit_in,
    input  logic             ack,
    output logic [WIDTH-1:0] word,
    output logic             vld,
    output logic             ovf
);
    import demux_pkg::*;

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;
    collect_t         cstate;
    out_t             ostate;
    logic [WIDTH-1:0] shifted;

    assign shifted = {sr, bit_in};
    assign vld     = (ostate == FULL);

    // A completion is a sample event while the collector is in LAST; the holding
    // stage either accepts it (empty or being acked) or drops it and flags overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            cnt    <= '0;
            cstate <= SHIFT;
            ostate <= EMPTY;
            word   <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            sr     <= '0;
            cnt    <= '0;
            cstate <= SHIFT;
            ostate <= EMPTY;
            word   <= '0;
            ovf    <= 1'b0;
        end else begin
            if (sample) begin
                sr <= shifted[WIDTH-2:0];
                if (cstate == LAST) begin
                    cnt    <= '0;
                    cstate <= SHIFT;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST - 1'b1)
                        cstate <= LAST;
                end
            end

            if (sample && cstate == LAST) begin
                if (ostate == EMPTY || ack) begin
                    word   <= shifted;
                    ostate <= FULL;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (ack && ostate == FULL) begin
                ostate <= EMPTY;
            end
        end
    end

endmodule

// File: rtl/demux_deser_2ch.sv
// Two-channel deserializer behind a 1x2 demux; sel routes each qualified bit to
// its channel and only din[sel] is ever sampled.
module demux_deser_2ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             sel,
    input  logic [1:0]       din,
    input  logic             clr,
    input  logic             ack0,
    input  logic             ack1,
    output logic [WIDTH-1:0] word0,
    output logic [WIDTH-1:0] word1,
    output logic             vld0,
    output logic             vld1,
    output logic             ovf0,
    output logic             ovf1
);
    import demux_pkg::*;

    logic sample0;
    logic sample1;

    assign sample0 = bit_valid & (sel == CH0);
    assign sample1 = bit_valid & (sel == CH1);

    deser_lane #(.WIDTH(WIDTH)) u_lane0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .sample (sample0),
        .bit_in (din[CH0]),
        .ack    (ack0),
        .word   (word0),
        .vld    (vld0),
        .ovf    (ovf0)
    );

    deser_lane #(.WIDTH(WIDTH)) u_lane1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .sample (sample1),
        .bit_in (din[CH1]),
        .ack    (ack1),
        .word   (word1),
        .vld    (vld1),
        .ovf    (ovf1)
    );

endmodule

// File: doc/demux_deser_2ch.md
# demux_deser_2ch

- Two-channel bit deserializer sitting directly downstream of the 1x2 demux; consumes the demux's two output lines plus the same `sel` and a per-sample `bit_valid` qualifier.
- Each channel assembles its steered bits, MSB first, into a WIDTH-bit word and presents it through a registered valid/ack holding stage with a sticky overflow flag.
- Used wherever a single serial source is time-shared between two byte-oriented consumers.

## Interface
- `WIDTH`, 8: bits per assembled word; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_valid`  in  1  qualifies `sel`/`din` this cycle.
- `sel`  in  1  channel the current bit was steered to (0 → ch0, 1 → ch1).
- `din`  in  2  demux outputs; only `din[sel]` is sampled.
- `clr`  in  1  synchronous clear of both channels.
- `ack0`, `ack1`  in  1 each  consumer accepts the held word.
- `word0`, `word1`  out  WIDTH each  held words.
- `vld0`, `vld1`  out  1 each  held word valid.
- `ovf0`, `ovf1`  out  1 each  sticky overflow.

## Operation
- Per channel c: shift register `sr` (WIDTH-1 bits), bit counter `cnt` (0..WIDTH-1), holding register, `vld`, `ovf`.
- Sample event: `bit_valid`=1 and `sel`=c.
  - `din[c]` is shifted in at the LSB; earlier bits move toward the MSB.
  - `cnt` increments on each sample event.
  - `din[~sel]` is never sampled.
  - `bit_valid`=0: no state changes anywhere.
- Collector FSM per channel:
  - SHIFT: `cnt` below WIDTH-1.
  - LAST: `cnt`=WIDTH-1. A sample event in LAST completes the word {`sr`, `din[c]`]}; `cnt` wraps to 0 and the FSM returns to SHIFT.
- Output stage per channel:
  - EMPTY (`vld`=0) or FULL (`vld`=1).
  - On completion:
    - EMPTY, or FULL with `ack`=1 the same cycle: load the word, `vld`=1.
    - FULL with `ack`=0: the new word is dropped. The holding register is unchanged, `ovf` is set, and the collector still restarts at `cnt`=0.
  - `ack` while FULL with no completion: `vld`=0, holding register keeps its value.
  - `ack` while EMPTY: ignored.
- `ovf` stays set until `clr` or reset.
- `clr`=1:
  - Zeroes `cnt`, `sr`, `vld` and `ovf` on both channels.
  - The holding registers are zeroed as well.
  - Overrides `bit_valid` and `ack` in the same cycle.
- Channels are fully independent; interleaving at bit granularity is legal.

## Timing
- Reset (async assert, deassert synchronized externally): every output is 0, `cnt`=0, `sr`=0. Reset asserted mid-word discards the partial word.
- Latency:
  - The word and `vld` appear on the clock edge that samples the final bit.
  - They are visible the cycle after the final bit is presented.
- `vld` stays high until the edge on which `ack` is sampled high. With back-to-back completion and `ack` on the same edge, `vld` stays 1 with the new word.
- `ovf` rises on the edge of the dropped completion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `demux_pkg`:
  - Constants `CH0 = 1'b0` and `CH1 = 1'b1`.
  - Enum for collector state {SHIFT, LAST}.
  - Enum for output state {EMPTY, FULL}.
  - Counter width derived as $clog2(WIDTH).
- Sub-module `deser_lane` (parameter WIDTH):
  - Ports: `clk`, `rst_n`, `clr`, `sample`, `bit_in`, `ack`, `word`, `vld`, `ovf`.
  - Instantiated twice.
- Top-level logic:
  - `sample` = `bit_valid & (sel==c)`.
  - `bit_in` = `din[c]`.

## Test plan
- **Reset mid-word:** drive 4 ch0 bits, pulse `rst_n` low, then drive 0xA5 MSB-first on ch0 → `word0`=0xA5 and `vld0`=1 one cycle after the 8th bit; before that, all outputs are 0.
- **Interleaved channels:** alternate `sel` per bit, ch0=0x3C and ch1=0xC3, with `din[~sel]` toggling randomly → `word0`=0x3C and `word1`=0xC3, each `vld` rising after its own 8th bit.
- **Overflow:** ch1 completes 0x11 with no ack, then completes 0x22 → `word1` stays 0x11 and `ovf1`=1. `ack1` then gives `vld1`=0 while `ovf1` stays 1. `clr` then gives `ovf1`=0.
- **Simultaneous ack and completion:** 0x55 held in ch0, and `ack0`=1 on the cycle of the 8th bit of 0xAA → `word0`=0xAA, `vld0` stays 1, `ovf0`=0.
- **Clear collision:** `clr` and a valid ch0 bit in the same cycle after 5 bits → `cnt`=0 and the bit is dropped; the next 8 bits 0x0F give `word0`=0x0F.
- **Gaps:** `bit_valid`=0 for 3 cycles between every bit of 0x96 on ch1 → `word1`=0x96 and ch0 is unaffected.
